// File: rtl/mem_stage_sram.sv
// MEM stage: LD/ST through a req/ready data memory.
// Non-memory ops pass in one cycle; memory ops freeze upstream.
module mem_stage_sram #(
  parameter logic [31:0] DATA_BASE = 32'd1024,
  parameter int          ADDR_W    = 16,
  parameter logic [7:0]  TIMEOUT   = 8'd64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WB_en_in,
  input  logic [1:0]        MEM_Signal_in,
  input  logic [4:0]        Dest_in,
  input  logic [31:0]       PC_in,
  input  logic [31:0]       ALU_result_in,
  input  logic [31:0]       reg2_in,
  output logic              freeze,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              WB_en,
  output logic              MEM_R_EN,
  output logic [4:0]        Dest,
  output logic [31:0]       PC,
  output logic [31:0]       ALU_result,
  output logic [31:0]       Mem_data,
  output logic              mem_err
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [7:0]  cnt;
  logic [31:0] rdata_q;
  logic        mem_op;
  logic        start;
  logic        ready_hit;
  logic        tmo_hit;
  logic        bubble;

  assign mem_op    = |MEM_Signal_in;
  assign start     = (state == IDLE) && mem_op;
  assign ready_hit = (state == ACCESS) && mem_ready;
  assign tmo_hit   = (state == ACCESS) && !mem_ready
                     && (cnt == TIMEOUT - 8'd1);
  assign bubble    = start || (state == ACCESS);

  // Freeze is gated by reset so it drops without a clock edge.
  assign freeze = rst && bubble;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state decode.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (mem_op) state_n = ACCESS;
      ACCESS:  if (ready_hit || tmo_hit) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Memory request, wait counter, captured read data, error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cnt       <= '0;
      rdata_q   <= '0;
      mem_err   <= 1'b0;
    end else if (start) begin
      mem_req   <= 1'b1;
      mem_we    <= ~MEM_Signal_in[1] & MEM_Signal_in[0];
      mem_addr  <= ADDR_W'((ALU_result_in - DATA_BASE) >> 2);
      mem_wdata <= reg2_in;
      cnt       <= '0;
    end else if (ready_hit) begin
      mem_req   <= 1'b0;
      rdata_q   <= mem_we ? 32'd0 : mem_rdata;
    end else if (tmo_hit) begin
      mem_req   <= 1'b0;
      mem_err   <= 1'b1;
      rdata_q   <= '0;
    end else if (state == ACCESS) begin
      cnt       <= cnt + 8'd1;
    end
  end

  // MEM/WB register: bubble while frozen, else load the instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      WB_en      <= 1'b0;
      MEM_R_EN   <= 1'b0;
      Dest       <= '0;
      PC         <= '0;
      ALU_result <= '0;
      Mem_data   <= '0;
    end else if (bubble) begin
      WB_en      <= 1'b0;
      MEM_R_EN   <= 1'b0;
      Dest       <= '0;
      PC         <= '0;
      ALU_result <= '0;
      Mem_data   <= '0;
    end else begin
      WB_en      <= WB_en_in;
      MEM_R_EN   <= MEM_Signal_in[1];
      Dest       <= Dest_in;
      PC         <= PC_in;
      ALU_result <= ALU_result_in;
      Mem_data   <= (state == DONE) ? rdata_q : 32'd0;
    end
  end

endmodule

// File: tb/tb_mem_stage_sram.sv
// Bench for mem_stage_sram: vector table, memory
// responder, scoreboard queue of retirements.
module tb_mem_stage_sram;

  logic        clk = 1'b0;
  logic        rst;
  logic        WB_en_in;
  logic [1:0]  MEM_Signal_in;
  logic [4:0]  Dest_in;
  logic [31:0] PC_in;
  logic [31:0] ALU_result_in;
  logic [31:0] reg2_in;
  logic        freeze;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        WB_en;
  logic        MEM_R_EN;
  logic [4:0]  Dest;
  logic [31:0] PC;
  logic [31:0] ALU_result;
  logic [31:0] Mem_data;
  logic        mem_err;

  mem_stage_sram #(
    .DATA_BASE(32'd1024),
    .ADDR_W(16),
    .TIMEOUT(8'd4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .WB_en_in(WB_en_in),
    .MEM_Signal_in(MEM_Signal_in),
    .Dest_in(Dest_in),
    .PC_in(PC_in),
    .ALU_result_in(ALU_result_in),
    .reg2_in(reg2_in),
    .freeze(freeze),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .WB_en(WB_en),
    .MEM_R_EN(MEM_R_EN),
    .Dest(Dest),
    .PC(PC),
    .ALU_result(ALU_result),
    .Mem_data(Mem_data),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wb;
    logic [1:0]  sig;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] r2;
    int          lat;
    logic        stray;
    logic        e_wb;
    logic        e_rd;
    logic [31:0] e_data;
    int          e_frz;
    logic [15:0] e_addr;
    logic        e_we;
    logic [31:0] e_wdata;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic        wb;
    logic        rd;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  vec_t        tbl[11];
  logic [31:0] model[256];
  int          cur_lat = 0;
  logic        stray = 1'b0;
  int          k = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory responder: ready on the cur_lat-th request cycle.
  always @(posedge clk) begin
    #2;
    if (mem_req) begin
      if (cur_lat != 0 && k == cur_lat - 1) begin
        mem_ready = 1'b1;
        if (mem_we) begin
          model[mem_addr[7:0]] = mem_wdata;
          mem_rdata = 32'hBAD0BAD0;
        end else begin
          mem_rdata = model[mem_addr[7:0]];
        end
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 32'hBAD0BAD0;
      end
      k++;
    end else begin
      k = 0;
      mem_ready = stray;
      mem_rdata = 32'hBAD0BAD0;
    end
  end

  task automatic issue(input string nm, input vec_t v);
    exp_t e;
    bit   f;
    bit   seen;
    bit   done;
    int   n;
    WB_en_in      = v.wb;
    MEM_Signal_in = v.sig;
    Dest_in       = v.dest;
    PC_in         = v.pc;
    ALU_result_in = v.alu;
    reg2_in       = v.r2;
    cur_lat       = v.lat;
    stray         = v.stray;
    e = '{v.e_wb, v.e_rd, v.dest, v.pc,
          v.alu, v.e_data, v.e_err};
    sb.push_back(e);
    n = 0;
    seen = 0;
    done = 0;
    for (int g = 0; g < 20; g++) begin
      #1 f = freeze;
      @(posedge clk);
      @(negedge clk);
      if (!f) begin
        done = 1;
        break;
      end
      n++;
      chk({nm, " bubble_wb"}, 32'(WB_en), 0);
      chk({nm, " bubble_rd"}, 32'(MEM_R_EN), 0);
      if (mem_req && !seen) begin
        seen = 1;
        chk({nm, " addr"}, 32'(mem_addr), 32'(v.e_addr));
        chk({nm, " we"}, 32'(mem_we), 32'(v.e_we));
        if (v.e_we)
          chk({nm, " wdata"}, mem_wdata, v.e_wdata);
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: freeze stuck", nm);
    end
    chk({nm, " freeze_cycles"}, n, v.e_frz);
    chk({nm, " req_seen"}, 32'(seen), 32'(v.e_frz > 0));
    e = sb.pop_front();
    chk({nm, " wb_en"}, 32'(WB_en), 32'(e.wb));
    chk({nm, " mem_r_en"}, 32'(MEM_R_EN), 32'(e.rd));
    chk({nm, " dest"}, 32'(Dest), 32'(e.dest));
    chk({nm, " pc"}, PC, e.pc);
    chk({nm, " alu"}, ALU_result, e.alu);
    chk({nm, " mem_data"}, Mem_data, e.data);
    chk({nm, " mem_err"}, 32'(mem_err), 32'(e.err));
    chk({nm, " req_idle"}, 32'(mem_req), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      model[i] = 32'hA5000000 + i;
    model[2] = 32'hDEADBEEF;

    //        wb sig dest pc  alu  r2 lat st
    //        e_wb e_rd e_data e_frz e_addr e_we e_wdata e_err
    tbl[0]  = '{1, 2'b00, 5'd5, 32'h100, 32'h10, 0, 0, 0,
                1, 0, 32'h0, 0, 16'd0, 0, 32'h0, 0};
    tbl[1]  = '{1, 2'b10, 5'd6, 32'h104, 32'd1032, 0, 3, 0,
                1, 1, 32'hDEADBEEF, 4, 16'd2, 0, 32'h0, 0};
    tbl[2]  = '{0, 2'b01, 5'd0, 32'h108, 32'd1028, 32'h1234, 2, 0,
                0, 0, 32'h0, 3, 16'd1, 1, 32'h1234, 0};
    tbl[3]  = '{1, 2'b10, 5'd7, 32'h10C, 32'd1028, 0, 1, 0,
                1, 1, 32'h1234, 2, 16'd1, 0, 32'h0, 0};
    tbl[4]  = '{1, 2'b11, 5'd8, 32'h110, 32'd1036, 32'h77, 1, 0,
                1, 1, 32'hA5000003, 2, 16'd3, 0, 32'h0, 0};
    tbl[5]  = '{1, 2'b10, 5'd9, 32'h114, 32'd1035, 0, 2, 0,
                1, 1, 32'hDEADBEEF, 3, 16'd2, 0, 32'h0, 0};
    tbl[6]  = '{1, 2'b00, 5'd31, 32'h118, 32'hFFFFFFFF, 0, 0, 1,
                1, 0, 32'h0, 0, 16'd0, 0, 32'h0, 0};
    tbl[7]  = '{1, 2'b10, 5'd10, 32'h11C, 32'd1040, 0, 1, 0,
                1, 1, 32'hA5000004, 2, 16'd4, 0, 32'h0, 0};
    tbl[8]  = '{1, 2'b10, 5'd11, 32'h120, 32'd1044, 0, 1, 0,
                1, 1, 32'hA5000005, 2, 16'd5, 0, 32'h0, 0};
    tbl[9]  = '{1, 2'b10, 5'd12, 32'h124, 32'd1048, 0, 0, 0,
                1, 1, 32'h0, 5, 16'd6, 0, 32'h0, 1};
    tbl[10] = '{1, 2'b00, 5'd13, 32'h128, 32'h55, 0, 0, 0,
                1, 0, 32'h0, 0, 16'd0, 0, 32'h0, 1};

    rst           = 1'b0;
    WB_en_in      = 1'b0;
    MEM_Signal_in = 2'b00;
    Dest_in       = '0;
    PC_in         = '0;
    ALU_result_in = '0;
    reg2_in       = '0;
    mem_ready     = 1'b0;
    mem_rdata     = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst freeze", 32'(freeze), 0);
    chk("rst mem_req", 32'(mem_req), 0);
    chk("rst wb_en", 32'(WB_en), 0);
    chk("rst mem_err", 32'(mem_err), 0);
    chk("rst mem_data", Mem_data, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++)
      issue($sformatf("vec%0d", i), tbl[i]);

    // Reset pulsed while a load waits in ACCESS.
    WB_en_in      = 1'b1;
    MEM_Signal_in = 2'b10;
    Dest_in       = 5'd14;
    PC_in         = 32'h12C;
    ALU_result_in = 32'd1052;
    cur_lat       = 0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("pre_rst req", 32'(mem_req), 1);
    chk("pre_rst freeze", 32'(freeze), 1);
    rst = 1'b0;
    #1;
    chk("async req", 32'(mem_req), 0);
    chk("async freeze", 32'(freeze), 0);
    chk("async wb_en", 32'(WB_en), 0);
    chk("async mem_r_en", 32'(MEM_R_EN), 0);
    chk("async dest", 32'(Dest), 0);
    chk("async pc", PC, 0);
    chk("async alu", ALU_result, 0);
    chk("async mem_data", Mem_data, 0);
    chk("async mem_err", 32'(mem_err), 0);
    WB_en_in      = 1'b0;
    MEM_Signal_in = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst freeze", 32'(freeze), 0);
    chk("post_rst req", 32'(mem_req), 0);
    issue("post_rst add", tbl[0]);
    issue("post_rst ld", tbl[1]);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
